sprite_draw: RTL and testbench
==============================

# sprite_draw

Executes the framebuffer side of the CHIP-8 DXYN draw instruction. It reads N sprite bytes from main memory and XORs each byte into the 64x32 1-bpp VRAM that the VGA scanout reads. It writes the modified bytes back and reports the collision flag for VF. The block sits between the CPU execute stage and the shared 12-bit/8-bit memory port.

## Interface

Parameters:
- VRAM_BASE, 12'hF00, byte address of framebuffer row 0 / column byte 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  single-cycle request to draw; sampled only in IDLE
- x_coord  in  8  sprite X (Vx)
- y_coord  in  8  sprite Y (Vy)
- rows  in  4  sprite height N
- sprite_addr  in  12  sprite base (I)
- busy  out  1  draw in progress
- done  out  1  one-cycle completion pulse
- collision  out  1  VF result; valid from done until next accepted start
- mem_addr  out  12  memory address, registered
- mem_we  out  1  write strobe, registered
- mem_wr_data  out  8  write data, registered
- mem_rd_data  in  8  read data; holds the value at the address driven in the previous cycle (1-cycle synchronous read)

## Operation

- Framebuffer layout: 8 bytes per row, 32 rows. Byte address = VRAM_BASE + y*8 + x/8. Bit 7 is the leftmost pixel.
- On accept, latch x0 = x_coord mod 64, y0 = y_coord mod 32, N, and I. Clear collision.
- For row r: s = mem[(I+r) mod 4096], yy = (y0+r) mod 32, xb = x0/8, sh = x0%8.
  - fb0 = byte (yy, xb) gets XOR s>>sh.
  - fb1 = byte (yy, xb+1) gets XOR (s<<(8-sh))[7:0]. Accessed only if sh≠0.
- Collision is set if any (old_byte & xor_mask) ≠ 0 over all writes.
- States: IDLE, SPR_RD, FB0_RD, FB1_RD, FB0_WR, FB1_WR, DONE.
- Per row, cycle by cycle:
  - SPR_RD: addr = I+r.
  - FB0_RD: addr = fb0; s captured.
  - FB1_RD: addr = fb1 if sh≠0, else idle; fb0 data captured.
  - FB0_WR: we = 1, fb0 written; fb1 data captured.
  - FB1_WR: only if fb1 is accessed; we = 1.
- Row cost: 4 cycles if fb1 is not accessed, 5 if it is.
- N = 0: no memory access. Go straight to DONE; collision = 0.
- start while busy: ignored.

## Timing

- Reset values: busy=0, done=0, collision=0, mem_we=0, mem_addr=0, mem_wr_data=0, state IDLE.
- start is sampled at cycle 0. busy=1 from cycle 1. The first SPR_RD is in cycle 1.
- DONE is the cycle after the last write. In DONE: done=1, busy=0. The next start is accepted in that cycle.
- Latency: done at cycle 1 + Σ row cost. Aligned draw of N rows: 4N+1. N=0: cycle 1.
- mem_we is high only in FB0_WR/FB1_WR. mem_addr and mem_wr_data hold their last value outside accesses.
- rst_n low mid-draw: go to IDLE on that edge and drop mem_we. Already-written bytes remain. No done pulse.

## Configuration

- SPRITE_WRAP_EN defined:
  - Rows past y=31 wrap to row 0.
  - fb1 column is (xb+1) mod 8, so pixels past x=63 wrap to column 0 of the same row.
- SPRITE_WRAP_EN undefined (clip):
  - The draw terminates at the first row with y0+r ≥ 32; DONE follows immediately.
  - fb1 is skipped when xb = 7, giving a 4-cycle row.
- The start coordinate is always taken mod 64/32 in both modes.

## Test plan

- Reset: hold rst_n=0 for 2 cycles -> all outputs 0, state IDLE.
- VRAM zero, mem[0x050]=0xF0, x=0, y=0, N=1, I=0x050 -> one write, 0xF00←0xF0, collision=0, done at cycle 5.
- Repeat the same draw -> 0xF00←0x00, collision=1, done at cycle 5.
- x=3, y=2, N=1, sprite 0xFF on zero VRAM -> 0xF10←0x1F, 0xF11←0xE0, collision=0, done at cycle 6.
- x=62, y=31, N=2, sprites 0xFF,0xFF on zero VRAM:
  - With SPRITE_WRAP_EN: 0xFFF←0x03, 0xFF8←0xFC, 0xF07←0x03, 0xF00←0xFC; done at cycle 11.
  - Without it: only 0xFFF←0x03; done at cycle 5.
- N=0 -> done at cycle 1, no mem_we. A start pulsed mid-draw -> ignored, and exactly one done pulse.

Source files
------------

// File: rtl/sprite_draw.sv
// CHIP-8 DXYN framebuffer engine: reads N sprite bytes and XORs them into the 64x32 1-bpp VRAM.
// Optional SPRITE_WRAP_EN: wrap rows past y=31 and pixels past x=63; otherwise the sprite is clipped.
module sprite_draw #(
  parameter logic [11:0] VRAM_BASE = 12'hF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  x_coord,
  input  logic [7:0]  y_coord,
  input  logic [3:0]  rows,
  input  logic [11:0] sprite_addr,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data
);

  typedef enum logic [2:0] {IDLE, SPR_RD, FB0_RD, FB1_RD, FB0_WR, FB1_WR, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  x0_q, x0_d;
  logic [4:0]  y0_q, y0_d;
  logic [3:0]  n_q, n_d;
  logic [3:0]  r_q, r_d;
  logic [11:0] i_q, i_d;
  logic [7:0]  s_q, s_d;
  logic        coll_q, coll_d;
  logic [11:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [4:0]  yy;
  logic [2:0]  xb, xb1, sh;
  logic [11:0] fb0_addr, fb1_addr;
  logic [15:0] mask_w;
  logic        fb1_acc;
  logic [3:0]  r_nx;
  logic        last_row;
  logic        unused_coord_bits;

  assign unused_coord_bits = ^{x_coord[7:6], y_coord[7:5]};

  always_comb begin
    yy       = y0_q + {1'b0, r_q};
    xb       = x0_q[5:3];
    sh       = x0_q[2:0];
    xb1      = xb + 3'd1;
    fb0_addr = VRAM_BASE + {4'b0, yy, xb};
    fb1_addr = VRAM_BASE + {4'b0, yy, xb1};
    // upper byte is the fb0 mask, lower byte the spill into fb1
    mask_w   = {s_q, 8'h00} >> sh;
    r_nx     = r_q + 4'd1;
`ifdef SPRITE_WRAP_EN
    fb1_acc  = (sh != 3'd0);
    last_row = (r_nx == n_q);
`else
    fb1_acc  = (sh != 3'd0) && (xb != 3'd7);
    last_row = (r_nx == n_q) || (({1'b0, y0_q} + {2'b0, r_nx}) >= 6'd32);
`endif
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    n_d     = n_q;
    r_d     = r_q;
    i_d     = i_q;
    s_d     = s_q;
    coll_d  = coll_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          x0_d   = x_coord[5:0];
          y0_d   = y_coord[4:0];
          n_d    = rows;
          i_d    = sprite_addr;
          r_d    = 4'd0;
          coll_d = 1'b0;
          if (rows == 4'd0) begin
            state_d = DONE;
          end else begin
            state_d = SPR_RD;
            addr_d  = sprite_addr;
          end
        end
      end
      SPR_RD: begin
        state_d = FB0_RD;
        addr_d  = fb0_addr;
      end
      FB0_RD: begin
        state_d = FB1_RD;
        s_d     = mem_rd_data;
        if (fb1_acc) addr_d = fb1_addr;
      end
      FB1_RD: begin
        state_d = FB0_WR;
        addr_d  = fb0_addr;
        we_d    = 1'b1;
        wdata_d = mem_rd_data ^ mask_w[15:8];
        coll_d  = coll_q | (|(mem_rd_data & mask_w[15:8]));
      end
      FB0_WR, FB1_WR: begin
        if (state_q == FB0_WR && fb1_acc) begin
          state_d = FB1_WR;
          addr_d  = fb1_addr;
          we_d    = 1'b1;
          wdata_d = mem_rd_data ^ mask_w[7:0];
          coll_d  = coll_q | (|(mem_rd_data & mask_w[7:0]));
        end else begin
          r_d = r_nx;
          if (last_row) begin
            state_d = DONE;
          end else begin
            state_d = SPR_RD;
            addr_d  = i_q + {8'b0, r_nx};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      n_q     <= '0;
      r_q     <= '0;
      i_q     <= '0;
      s_q     <= '0;
      coll_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      n_q     <= n_d;
      r_q     <= r_d;
      i_q     <= i_d;
      s_q     <= s_d;
      coll_q  <= coll_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign collision   = coll_q;
  assign mem_addr    = addr_q;
  assign mem_we      = we_q;
  assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw: behavioural 1-cycle-read memory, hand-computed VRAM/latency expectations.
module tb_sprite_draw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  x_coord, y_coord;
  logic [3:0]  rows;
  logic [11:0] sprite_addr;
  logic        busy, done, collision;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;

  logic [7:0]  mem [0:4095];
  logic        clr_all;
  logic        tb_we;
  logic [11:0] tb_addr;
  logic [7:0]  tb_data;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int lat, wr0, dn0;

  always #5 clk = ~clk;

  sprite_draw #(.VRAM_BASE(12'hF00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_coord(x_coord), .y_coord(y_coord),
    .rows(rows), .sprite_addr(sprite_addr), .busy(busy), .done(done), .collision(collision),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always @(posedge clk) begin
    if (clr_all) begin
      for (int a = 0; a < 4096; a++) mem[a] <= 8'h00;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) wr_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic clear_mem();
    @(negedge clk);
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
  endtask

  task automatic run_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                          input logic [11:0] i, input int mid_at, output int l);
    l = -1;
    @(negedge clk);
    x_coord = x; y_coord = y; rows = n; sprite_addr = i; start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) begin
        l = c;
        break;
      end
      start = (c == mid_at);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; x_coord = '0; y_coord = '0; rows = '0; sprite_addr = '0;
    clr_all = 1'b1; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr_all = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_coll", collision, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wr_data, 0);
    rst_n = 1'b1;

    poke(12'h050, 8'hF0);
    poke(12'h051, 8'hFF);
    poke(12'h060, 8'hFF);
    poke(12'h061, 8'hFF);

    wr0 = wr_cnt;
    run_draw(8'd0, 8'd0, 4'd1, 12'h050, 0, lat);
    chk("a_lat", lat, 5);
    chk("a_f00", mem[12'hF00], 8'hF0);
    chk("a_coll", collision, 0);
    chk("a_writes", wr_cnt - wr0, 1);

    run_draw(8'd0, 8'd0, 4'd1, 12'h050, 0, lat);
    chk("b_lat", lat, 5);
    chk("b_f00", mem[12'hF00], 8'h00);
    chk("b_coll", collision, 1);

    wr0 = wr_cnt;
    run_draw(8'd10, 8'd3, 4'd0, 12'h050, 0, lat);
    chk("n0_lat", lat, 1);
    chk("n0_writes", wr_cnt - wr0, 0);
    chk("n0_coll", collision, 0);

    wr0 = wr_cnt;
    run_draw(8'd3, 8'd2, 4'd1, 12'h051, 0, lat);
    chk("c_lat", lat, 6);
    chk("c_f10", mem[12'hF10], 8'h1F);
    chk("c_f11", mem[12'hF11], 8'hE0);
    chk("c_coll", collision, 0);
    chk("c_writes", wr_cnt - wr0, 2);

    wr0 = wr_cnt;
    run_draw(8'd62, 8'd31, 4'd2, 12'h060, 0, lat);
    chk("d_fff", mem[12'hFFF], 8'h03);
    chk("d_coll", collision, 0);
`ifdef SPRITE_WRAP_EN
    chk("d_lat", lat, 11);
    chk("d_ff8", mem[12'hFF8], 8'hFC);
    chk("d_f07", mem[12'hF07], 8'h03);
    chk("d_f00", mem[12'hF00], 8'hFC);
    chk("d_writes", wr_cnt - wr0, 4);
`else
    chk("d_lat", lat, 5);
    chk("d_ff8", mem[12'hFF8], 8'h00);
    chk("d_f07", mem[12'hF07], 8'h00);
    chk("d_writes", wr_cnt - wr0, 1);
`endif

    clear_mem();
    poke(12'h050, 8'hF0);
    poke(12'h051, 8'hFF);
    run_draw(8'd72, 8'd33, 4'd1, 12'h050, 0, lat);
    chk("mod_lat", lat, 5);
    chk("mod_f09", mem[12'hF09], 8'hF0);

    dn0 = done_cnt;
    run_draw(8'd0, 8'd5, 4'd2, 12'h050, 2, lat);
    repeat (3) @(negedge clk);
    chk("mid_lat", lat, 9);
    chk("mid_f28", mem[12'hF28], 8'hF0);
    chk("mid_f30", mem[12'hF30], 8'hFF);
    chk("mid_dones", done_cnt - dn0, 1);

    clear_mem();
    poke(12'h050, 8'hF0);
    poke(12'h051, 8'hFF);
    dn0 = done_cnt;
    @(negedge clk);
    x_coord = 8'd0; y_coord = 8'd0; rows = 4'd3; sprite_addr = 12'h050; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_f00", mem[12'hF00], 8'hF0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_mid_f08", mem[12'hF08], 8'h00);
    chk("rst_mid_dones", done_cnt - dn0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
